// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_pkg                                                      |
// | Description : Shared definitions for the 16-bit APB register bus: bus      |
// |               widths, transfer state encoding and slave register map.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package apb_pkg;

  // Bus widths: address, data and byte-strobe lanes.
  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 16;
  localparam int unsigned APB_SW = 2;

  // Register map of the PWM register slave.
  localparam logic [APB_AW-1:0] MEM0 = 32'd0;
  localparam logic [APB_AW-1:0] MEM1 = 32'd1;

  // Initiator transfer phase.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_timeout_cnt                                              |
// | Description : Wait-state watchdog for one APB transfer. Counts ACCESS      |
// |               cycles in which the completer holds pready low and flags     |
// |               the cycle in which the count reaches TIMEOUT_CYC.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   pclk   in  1 : bus clock, rising edge                                    |
// |   rsn    in  1 : asynchronous active-low reset                             |
// |   clr    in  1 : restart count (new transfer entering SETUP)               |
// |   en     in  1 : ACCESS cycle with pready low                              |
// |   expire out 1 : this stalled cycle is the TIMEOUT_CYC-th one              |
// +----------------------------------------------------------------------------+
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic pclk,
  input  logic rsn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // Count reaches TIMEOUT_CYC on the edge that ends the stalled cycle in
  // which the counter still reads TIMEOUT_CYC-1, so abort is taken there.
  localparam logic [15:0] c_last = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;

  always_ff @(posedge pclk or negedge rsn) begin
    if (!rsn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign expire = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_master                                                   |
// | Description : APB initiator. Takes single read/write commands on a         |
// |               valid/ready port, runs SETUP/ACCESS toward the slaves,       |
// |               waits on pready and returns data/error on a one-cycle        |
// |               response strobe. Back-to-back commands keep psel high.       |
// | Option      : APB_MASTER_TIMEOUT_EN - abort a transfer after TIMEOUT_CYC   |
// |               stalled ACCESS cycles with rsp_err=1, rsp_rdata=0.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   pclk, rsn                      : clock, async active-low reset           |
// |   cmd_valid/cmd_ready            : command handshake                       |
// |   cmd_write/addr/wdata/strb      : command payload                         |
// |   rsp_valid/rsp_rdata/rsp_err    : one-cycle response                      |
// |   paddr/pwdata/pwrite/psel/penable/pstrb : APB request (registered)        |
// |   prdata/pready/pslverr          : APB completer                           |
// +----------------------------------------------------------------------------+
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              pclk,
  input  logic              rsn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  input  logic [APB_SW-1:0] cmd_strb,
  output logic              rsp_valid,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [APB_AW-1:0] paddr,
  output logic [APB_DW-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [APB_SW-1:0] pstrb,
  input  logic [APB_DW-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        r_state, w_state_nxt;
  logic [APB_AW-1:0] r_paddr, w_paddr_nxt;
  logic [APB_DW-1:0] r_pwdata, w_pwdata_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic              r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic [APB_SW-1:0] r_pstrb, w_pstrb_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [APB_DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              w_load;
  logic              w_expire;

  // A new command can be taken when idle, and also on the completing ACCESS
  // cycle so that a waiting command chains straight into SETUP.
  assign cmd_ready = (r_state == IDLE) || ((r_state == ACCESS) && pready);

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .pclk   (pclk),
    .rsn    (rsn),
    .clr    (w_load),
    .en     ((r_state == ACCESS) && !pready),
    .expire (w_expire)
  );
`else
  // Without the watchdog ACCESS waits for pready indefinitely.
  logic [15:0] w_unused_tmo;
  assign w_unused_tmo = 16'(TIMEOUT_CYC);
  assign w_expire     = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_pwrite_nxt    = r_pwrite;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pstrb_nxt     = r_pstrb;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_load          = 1'b0;

    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_load        = 1'b1;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = SETUP;
        end
      end

      SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ACCESS;
      end

      ACCESS: begin
        // pready has priority over a watchdog expiry in the same cycle.
        if (pready) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = pslverr;
          if (!r_pwrite) begin
            w_rsp_rdata_nxt = prdata;
          end
          w_penable_nxt = 1'b0;
          if (cmd_valid) begin
            w_load      = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_psel_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end
        end else if (w_expire) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_state_nxt     = IDLE;
        end
      end

      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase

    // Request fields are captured only when a command is accepted; they
    // hold their last values through ACCESS and while idle.
    if (w_load) begin
      w_paddr_nxt  = cmd_addr;
      w_pwdata_nxt = cmd_wdata;
      w_pwrite_nxt = cmd_write;
      w_pstrb_nxt  = cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge pclk or negedge rsn) begin
    if (!rsn) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pstrb     <= w_pstrb_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_apb_master                                                |
// | Description : Self-checking bench for apb_master: directed vector table,   |
// |               back-to-back, wait/timeout, reset and a randomized run       |
// |               against a memory-backed reference model.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int          N_RAND     = 60;

  logic        pclk = 1'b0;
  logic        rsn  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [15:0] cmd_wdata = '0;
  logic [1:0]  cmd_strb  = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite, psel, penable;
  logic [1:0]  pstrb;
  logic [15:0] prdata;
  logic        pready, pslverr;

  // Completer inputs come either from directed code or from the slave model.
  logic        auto_slave = 1'b0;
  logic        m_pready = 1'b0, m_pslverr = 1'b0;
  logic [15:0] m_prdata = '0;
  logic        s_pready = 1'b0, s_pslverr = 1'b0;
  logic [15:0] s_prdata = '0;
  assign pready  = auto_slave ? s_pready  : m_pready;
  assign pslverr = auto_slave ? s_pslverr : m_pslverr;
  assign prdata  = auto_slave ? s_prdata  : m_prdata;

  apb_master #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .pclk(pclk), .rsn(rsn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_psel"},      psel,      0);
    chk({tag, "_penable"},   penable,   0);
    chk({tag, "_pwrite"},    pwrite,    0);
    chk({tag, "_paddr"},     paddr,     0);
    chk({tag, "_pwdata"},    pwdata,    0);
    chk({tag, "_pstrb"},     pstrb,     0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    int          waits;
    logic [15:0] prdata;
    logic        slverr;
    logic [1:0]  exp_pstrb;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  // One isolated transfer, driven and checked cycle by cycle.
  task automatic run_xfer(input vec_t v);
    @(negedge pclk);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb;
    m_pready = 1'b0; m_pslverr = 1'b0;
    @(negedge pclk);
    // Scramble the command port: the bus must hold the captured values.
    cmd_valid = 1'b0; cmd_write = ~v.write; cmd_addr = ~v.addr;
    cmd_wdata = ~v.wdata; cmd_strb = ~v.strb;
    chk("setup_psel",    psel,    1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr",   paddr,   v.addr);
    chk("setup_pwrite",  pwrite,  v.write);
    chk("setup_pwdata",  pwdata,  v.wdata);
    chk("setup_pstrb",   pstrb,   v.exp_pstrb);
    chk("setup_rsp",     rsp_valid, 0);
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge pclk);
      m_pready  = (i == v.waits);
      m_pslverr = (i == v.waits) ? v.slverr : 1'b1;   // error on a wait cycle is ignored
      m_prdata  = (i == v.waits) ? v.prdata : ~v.prdata;
      #1;
      chk("acc_psel_penable", {30'd0, psel, penable}, 3);
      chk("acc_paddr",  paddr,  v.addr);
      chk("acc_pwdata", pwdata, v.wdata);
      chk("acc_pwrite", pwrite, v.write);
      chk("acc_pstrb",  pstrb,  v.exp_pstrb);
      chk("acc_rsp",    rsp_valid, 0);
      chk("acc_cmd_ready", cmd_ready, (i == v.waits) ? 1 : 0);
    end
    @(negedge pclk);
    m_pready = 1'b0; m_pslverr = 1'b0;
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("done_rsp_err",   rsp_err,   v.exp_err);
    chk("done_psel",      psel,      0);
    chk("done_penable",   penable,   0);
    @(negedge pclk);
    chk("after_rsp_valid", rsp_valid, 0);
    chk("idle_paddr_held", paddr, v.addr);
  endtask

  // Randomized-phase state: reference memory and expected response queue.
  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [15:0] ref_mem   [16];
  logic [15:0] slave_mem [16];
  logic [15:0] exp_last = '0;
  logic        rand_run = 1'b0;
  int          n_rsp = 0;

  initial begin
    int   bad;
    int   guard;
    int   s_wleft;
    logic s_in_acc;
    rsp_t e;

    vecs[0] = '{1'b1, MEM0,          16'h00A5, 2'b01, 0, 16'hDEAD, 1'b0, 2'b01, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, MEM1,          16'h0000, 2'b11, 3, 16'h1234, 1'b0, 2'b00, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, MEM1,          16'hBEEF, 2'b11, 1, 16'h5555, 1'b1, 2'b11, 16'h1234, 1'b1};
    vecs[3] = '{1'b0, MEM0,          16'h7E7E, 2'b10, 0, 16'h00A5, 1'b1, 2'b00, 16'h00A5, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0004, 16'h5A5A, 2'b10, 2, 16'h0F0F, 1'b0, 2'b10, 16'h00A5, 1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFC, 16'hC3C3, 2'b01, 0, 16'hFFFF, 1'b0, 2'b00, 16'hFFFF, 1'b0};

    // Reset state, checked while reset is held and after release.
    #12;
    chk_reset_outs("rst");
    @(negedge pclk);
    rsn = 1'b1;
    @(negedge pclk);
    chk_reset_outs("post_rst");

    // Directed vector table.
    for (int k = 0; k < 6; k++) begin
      run_xfer(vecs[k]);
      exp_last = vecs[k].exp_rdata;
    end

    // Back-to-back: write MEM0 then read MEM1 with cmd_valid held high.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = MEM0; cmd_wdata = 16'h1111; cmd_strb = 2'b11;
    @(negedge pclk);
    chk("b2b_setup1_psel", psel, 1);
    cmd_write = 1'b0; cmd_addr = MEM1; cmd_wdata = 16'h2222;
    @(negedge pclk);
    m_pready = 1'b1; m_prdata = 16'h7777; m_pslverr = 1'b0;
    #1;
    chk("b2b_ready_on_done", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0; m_prdata = 16'h4242;
    chk("b2b_setup2_psel",    psel,      1);
    chk("b2b_setup2_penable", penable,   0);
    chk("b2b_setup2_paddr",   paddr,     MEM1);
    chk("b2b_setup2_pstrb",   pstrb,     0);
    chk("b2b_rsp1_valid",     rsp_valid, 1);
    chk("b2b_rsp1_rdata",     rsp_rdata, exp_last);
    @(negedge pclk);
    chk("b2b_acc2_psel",  {30'd0, psel, penable}, 3);
    chk("b2b_gap_rsp",    rsp_valid, 0);
    @(negedge pclk);
    m_pready = 1'b0;
    chk("b2b_rsp2_valid", rsp_valid, 1);
    chk("b2b_rsp2_rdata", rsp_rdata, 16'h4242);
    chk("b2b_end_psel",   psel,      0);
    exp_last = 16'h4242;

    // Stalled completer.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = MEM1; cmd_wdata = 16'h0; cmd_strb = 2'b00;
    m_pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
      @(negedge pclk);
      if (!(psel && penable) || rsp_valid) bad++;
    end
    chk("tmo_access_cycles", bad, 0);
    @(negedge pclk);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err",   rsp_err,   1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    chk("tmo_psel",      {30'd0, psel, penable}, 0);
    exp_last = 16'h0000;
    @(negedge pclk);
    chk("tmo_after_rsp", rsp_valid, 0);
    chk("tmo_cmd_ready", cmd_ready, 1);
`else
    bad = 0;
    repeat (1000) begin
      @(negedge pclk);
      if (!(psel && penable) || rsp_valid) bad++;
    end
    chk("wait_1000_cycles", bad, 0);
    m_pready = 1'b1; m_prdata = 16'h3C3C;
    @(negedge pclk);
    m_pready = 1'b0;
    chk("wait_rsp_valid", rsp_valid, 1);
    chk("wait_rsp_rdata", rsp_rdata, 16'h3C3C);
    chk("wait_rsp_err",   rsp_err,   0);
    exp_last = 16'h3C3C;
`endif

    // Reset asserted in the middle of ACCESS.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0013; cmd_wdata = 16'hABCD; cmd_strb = 2'b11;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    #2 rsn = 1'b0;
    #1;
    chk_reset_outs("midrst");
    m_pready = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge pclk);
      if (rsp_valid || psel) bad++;
    end
    rsn = 1'b1; m_pready = 1'b0;
    @(negedge pclk);
    if (rsp_valid || psel) bad++;
    chk("midrst_no_response", bad, 0);
    exp_last = 16'h0000;
    run_xfer(vecs[1]);
    exp_last = vecs[1].exp_rdata;

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      slave_mem[i] = '0;
    end
    auto_slave = 1'b1;
    rand_run   = 1'b1;
    s_in_acc   = 1'b0;
    s_wleft    = 0;
    fork
      begin : drv
        for (int k = 0; k < N_RAND; k++) begin
          cmd_valid = 1'b1;
          cmd_write = 1'($urandom_range(0, 1));
          cmd_addr  = $urandom;
          cmd_wdata = 16'($urandom);
          cmd_strb  = 2'($urandom_range(0, 3));
          #1;
          guard = 0;
          while (!cmd_ready && guard < 50) begin
            @(negedge pclk);
            #1;
            guard++;
          end
          if (!cmd_ready) begin
            chk("rand_accept_timeout", 0, 1);
            break;
          end
          if (cmd_addr[5:4] == 2'b11) begin
            e.err = 1'b1;
          end else begin
            e.err = 1'b0;
          end
          if (cmd_write) begin
            if (!e.err) begin
              if (cmd_strb[0]) ref_mem[cmd_addr[3:0]][7:0]  = cmd_wdata[7:0];
              if (cmd_strb[1]) ref_mem[cmd_addr[3:0]][15:8] = cmd_wdata[15:8];
            end
          end else begin
            exp_last = ref_mem[cmd_addr[3:0]];
          end
          e.rdata = exp_last;
          exp_q.push_back(e);
          @(negedge pclk);
          if ($urandom_range(0, 2) != 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge pclk);
          end
        end
        cmd_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
          @(negedge pclk);
          guard++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_rsp_count", n_rsp, N_RAND);
        rand_run = 1'b0;
      end
      begin : slv
        while (rand_run) begin
          @(posedge pclk);
          #1;
          if (psel && penable) begin
            if (!s_in_acc) begin
              s_in_acc = 1'b1;
              s_wleft  = $urandom_range(0, 3);
            end
            if (s_wleft == 0) begin
              s_pready  = 1'b1;
              s_prdata  = slave_mem[paddr[3:0]];
              s_pslverr = (paddr[5:4] == 2'b11);
              if (pwrite && !s_pslverr) begin
                if (pstrb[0]) slave_mem[paddr[3:0]][7:0]  = pwdata[7:0];
                if (pstrb[1]) slave_mem[paddr[3:0]][15:8] = pwdata[15:8];
              end
            end else begin
              s_pready  = 1'b0;
              s_pslverr = 1'($urandom_range(0, 1));
              s_prdata  = 16'($urandom);
              s_wleft--;
            end
          end else begin
            s_in_acc  = 1'b0;
            s_pready  = 1'b0;
            s_pslverr = 1'b0;
          end
        end
      end
      begin : mon
        rsp_t m;
        while (rand_run) begin
          @(negedge pclk);
          if (rsp_valid) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected_rsp", 1, 0);
            end else begin
              m = exp_q.pop_front();
              chk("rand_rsp_rdata", rsp_rdata, m.rdata);
              chk("rand_rsp_err",   rsp_err,   m.err);
              n_rsp++;
            end
          end
        end
      end
    join
    auto_slave = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
